// File: rtl/battle_turn_ctrl.sv
// Turn-based battle sequencer feeding battle_module.
// Player turn: a key press is resolved into a damage strobe on enemy_hit.
// Enemy turn: after a fixed delay a damage strobe lands on player_hit.
// HP fed back from battle_module ends the battle.
`timescale 1ns / 1ps

module battle_turn_ctrl #(
  parameter int unsigned PLAYER_DMG_BASE = 10,
  parameter int unsigned ENEMY_DMG_BASE  = 8,
  parameter int unsigned BOSS_DMG_BONUS  = 6,
  parameter int unsigned ENEMY_DELAY     = 16,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter bit          FORCE_HIT       = 1'b0
) (
  input  logic       clk_b,
  input  logic       rst,
  input  logic       col_e,
  input  logic       boss,
  input  logic       key_valid,
  input  logic [7:0] key_in,
  input  logic [7:0] hp_player,
  input  logic [7:0] hp_enemy,
  output logic [6:0] player_hit,
  output logic [7:0] enemy_hit,
  output logic       hit_valid,
  output logic [2:0] p_attack,
  output logic [2:0] e_attack,
  output logic       battle_active,
  output logic       battle_over,
  output logic       player_won
);

  localparam int unsigned CntW = (ENEMY_DELAY > 1) ? $clog2(ENEMY_DELAY) : 1;

  localparam logic [7:0] KeyNormal = 8'h1C;
  localparam logic [7:0] KeyHeavy  = 8'h1B;
  localparam logic [7:0] KeyGuard  = 8'h23;

  localparam logic [2:0] PActNone   = 3'd0;
  localparam logic [2:0] PActNormal = 3'd1;
  localparam logic [2:0] PActHeavy  = 3'd2;
  localparam logic [2:0] PActGuard  = 3'd3;
  localparam logic [2:0] PActMiss   = 3'd4;

  localparam logic [2:0] EActNone = 3'd0;
  localparam logic [2:0] EActHit  = 3'd1;
  localparam logic [2:0] EActBoss = 3'd2;
  localparam logic [2:0] EActMiss = 3'd4;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StPWait,
    StPResolve,
    StCheckE,
    StEDelay,
    StEResolve,
    StCheckP,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [7:0]      lfsr_q, lfsr_d;
  logic            guard_q, guard_d;
  logic            boss_q, boss_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [6:0] player_hit_q, player_hit_d;
  logic [7:0] enemy_hit_q, enemy_hit_d;
  logic       hit_valid_q, hit_valid_d;
  logic [2:0] p_attack_q, p_attack_d;
  logic [2:0] e_attack_q, e_attack_d;
  logic       battle_active_q, battle_active_d;
  logic       battle_over_q, battle_over_d;
  logic       player_won_q, player_won_d;

  // Damage terms. Strobes are registered, so they are computed from lfsr_d:
  // the LFSR value that is visible during the resolve cycle itself.
  logic [3:0] rnd_r;
  logic [2:0] rnd_lo;
  logic       norm_hits, heavy_hits, enemy_miss;
  logic [8:0] norm_sum, heavy_sum, enemy_sum, enemy_dmg;
  logic [7:0] norm_sat, heavy_sat;
  logic [6:0] enemy_sat;

  // LFSR next value, x^8+x^6+x^5+x^4+1 shifting toward the MSB
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Damage arithmetic in 9 bits, saturated to each output width
  always_comb begin
    rnd_r      = FORCE_HIT ? 4'd0 : lfsr_d[3:0];
    rnd_lo     = FORCE_HIT ? 3'd0 : lfsr_d[2:0];
    norm_hits  = FORCE_HIT || (lfsr_d[3:0] >= 4'd2);
    heavy_hits = FORCE_HIT || (lfsr_d[3:0] >= 4'd8);
    enemy_miss = !FORCE_HIT && (lfsr_d[7:5] == 3'd0);

    norm_sum  = 9'(PLAYER_DMG_BASE) + {6'd0, rnd_lo};
    heavy_sum = 9'(2 * PLAYER_DMG_BASE) + {5'd0, rnd_r};
    norm_sat  = norm_sum[8] ? 8'hFF : norm_sum[7:0];
    heavy_sat = heavy_sum[8] ? 8'hFF : heavy_sum[7:0];

    enemy_sum = 9'(ENEMY_DMG_BASE) + {6'd0, rnd_lo} + (boss_q ? 9'(BOSS_DMG_BONUS) : 9'd0);
    enemy_dmg = guard_q ? (enemy_sum >> 1) : enemy_sum;
    enemy_sat = (enemy_dmg[8:7] != 2'b00) ? 7'h7F : enemy_dmg[6:0];
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    boss_d       = boss_q;
    cnt_d        = cnt_q;
    player_hit_d = 7'd0;
    enemy_hit_d  = 8'd0;
    hit_valid_d  = 1'b0;
    p_attack_d   = p_attack_q;
    e_attack_d   = e_attack_q;
    player_won_d = player_won_q;

    unique case (state_q)
      StIdle: begin
        if (col_e) state_d = StStart;
      end
      StStart: begin
        boss_d     = boss;
        p_attack_d = PActNone;
        e_attack_d = EActNone;
        guard_d    = 1'b0;
        state_d    = StPWait;
      end
      StPWait: begin
        if (key_valid) begin
          case (key_in)
            KeyNormal: begin
              state_d     = StPResolve;
              hit_valid_d = 1'b1;
              enemy_hit_d = norm_hits ? norm_sat : 8'd0;
              p_attack_d  = norm_hits ? PActNormal : PActMiss;
            end
            KeyHeavy: begin
              state_d     = StPResolve;
              hit_valid_d = 1'b1;
              enemy_hit_d = heavy_hits ? heavy_sat : 8'd0;
              p_attack_d  = heavy_hits ? PActHeavy : PActMiss;
            end
            KeyGuard: begin
              state_d     = StPResolve;
              hit_valid_d = 1'b1;
              guard_d     = 1'b1;
              p_attack_d  = PActGuard;
            end
            default: ;
          endcase
        end
      end
      StPResolve: begin
        state_d = StCheckE;
      end
      StCheckE: begin
        if (hp_enemy == 8'd0) begin
          state_d      = StDone;
          player_won_d = 1'b1;
        end else begin
          cnt_d   = CntW'(ENEMY_DELAY - 1);
          state_d = StEDelay;
        end
      end
      StEDelay: begin
        if (cnt_q == '0) begin
          state_d      = StEResolve;
          hit_valid_d  = 1'b1;
          player_hit_d = enemy_miss ? 7'd0 : enemy_sat;
          e_attack_d   = enemy_miss ? EActMiss : (boss_q ? EActBoss : EActHit);
          guard_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StEResolve: begin
        state_d = StCheckP;
      end
      StCheckP: begin
        if (hp_player == 8'd0) begin
          state_d      = StDone;
          player_won_d = 1'b0;
        end else begin
          state_d = StPWait;
        end
      end
      StDone: begin
        if (!col_e) begin
          state_d      = StIdle;
          player_won_d = 1'b0;
          p_attack_d   = PActNone;
          e_attack_d   = EActNone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags follow the state being entered so they line up with it
    battle_active_d = (state_d != StIdle) && (state_d != StDone);
    battle_over_d   = (state_d == StDone);
  end

  // State, LFSR and registered outputs; reset aborts any battle in progress
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q         <= StIdle;
      lfsr_q          <= LFSR_SEED;
      guard_q         <= 1'b0;
      boss_q          <= 1'b0;
      cnt_q           <= '0;
      player_hit_q    <= 7'd0;
      enemy_hit_q     <= 8'd0;
      hit_valid_q     <= 1'b0;
      p_attack_q      <= PActNone;
      e_attack_q      <= EActNone;
      battle_active_q <= 1'b0;
      battle_over_q   <= 1'b0;
      player_won_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      guard_q         <= guard_d;
      boss_q          <= boss_d;
      cnt_q           <= cnt_d;
      player_hit_q    <= player_hit_d;
      enemy_hit_q     <= enemy_hit_d;
      hit_valid_q     <= hit_valid_d;
      p_attack_q      <= p_attack_d;
      e_attack_q      <= e_attack_d;
      battle_active_q <= battle_active_d;
      battle_over_q   <= battle_over_d;
      player_won_q    <= player_won_d;
    end
  end

  assign player_hit    = player_hit_q;
  assign enemy_hit     = enemy_hit_q;
  assign hit_valid     = hit_valid_q;
  assign p_attack      = p_attack_q;
  assign e_attack      = e_attack_q;
  assign battle_active = battle_active_q;
  assign battle_over   = battle_over_q;
  assign player_won    = player_won_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Bench for battle_turn_ctrl: a FORCE_HIT instance driven from a vector table
// plus corner sequences, and a random-mode instance checked against a model.
`timescale 1ns / 1ps

module tb_battle_turn_ctrl;

  localparam int unsigned R_DELAY = 5;
  localparam int unsigned R_PBASE = 125;
  localparam int unsigned R_EBASE = 120;
  localparam int unsigned R_BONUS = 6;
  localparam logic [7:0]  R_SEED  = 8'h5C;

  logic clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  // FORCE_HIT instance, default parameters
  logic       f_rst = 1'b1, f_col_e = 1'b0, f_boss = 1'b0, f_key_valid = 1'b0;
  logic [7:0] f_key_in = 8'h00, f_hp_player = 8'd100, f_hp_enemy = 8'd80;
  logic [6:0] f_player_hit;
  logic [7:0] f_enemy_hit;
  logic       f_hit_valid, f_battle_active, f_battle_over, f_player_won;
  logic [2:0] f_p_attack, f_e_attack;

  // Random-mode instance
  logic       r_rst = 1'b1, r_col_e = 1'b0, r_boss = 1'b0, r_key_valid = 1'b0;
  logic [7:0] r_key_in = 8'h00, r_hp_player = 8'd255, r_hp_enemy = 8'd255;
  logic [6:0] r_player_hit;
  logic [7:0] r_enemy_hit;
  logic       r_hit_valid, r_battle_active, r_battle_over, r_player_won;
  logic [2:0] r_p_attack, r_e_attack;

  battle_turn_ctrl #(.FORCE_HIT(1'b1)) dut_f (
    .clk_b(clk_b), .rst(f_rst), .col_e(f_col_e), .boss(f_boss),
    .key_valid(f_key_valid), .key_in(f_key_in),
    .hp_player(f_hp_player), .hp_enemy(f_hp_enemy),
    .player_hit(f_player_hit), .enemy_hit(f_enemy_hit), .hit_valid(f_hit_valid),
    .p_attack(f_p_attack), .e_attack(f_e_attack),
    .battle_active(f_battle_active), .battle_over(f_battle_over), .player_won(f_player_won)
  );

  battle_turn_ctrl #(
    .PLAYER_DMG_BASE(R_PBASE), .ENEMY_DMG_BASE(R_EBASE), .BOSS_DMG_BONUS(R_BONUS),
    .ENEMY_DELAY(R_DELAY), .LFSR_SEED(R_SEED), .FORCE_HIT(1'b0)
  ) dut_r (
    .clk_b(clk_b), .rst(r_rst), .col_e(r_col_e), .boss(r_boss),
    .key_valid(r_key_valid), .key_in(r_key_in),
    .hp_player(r_hp_player), .hp_enemy(r_hp_enemy),
    .player_hit(r_player_hit), .enemy_hit(r_enemy_hit), .hit_valid(r_hit_valid),
    .p_attack(r_p_attack), .e_attack(r_e_attack),
    .battle_active(r_battle_active), .battle_over(r_battle_over), .player_won(r_player_won)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference LFSR: feedback is the parity of the x^8,x^6,x^5,x^4 tap bits
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  logic [7:0] m_lfsr;
  always @(posedge clk_b) m_lfsr <= r_rst ? R_SEED : lfsr_next(m_lfsr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk_zero(input string name, input bit rnd);
    if (rnd)
      chk(name, {r_player_hit, r_enemy_hit, r_hit_valid, r_p_attack, r_e_attack,
                 r_battle_active, r_battle_over, r_player_won}, 0);
    else
      chk(name, {f_player_hit, f_enemy_hit, f_hit_valid, f_p_attack, f_e_attack,
                 f_battle_active, f_battle_over, f_player_won}, 0);
  endtask

  // Cycles until the next strobe (-1 if none within the bound); optionally
  // throws keys at the forced instance while it is in its enemy delay.
  task automatic wait_strobe(input bit rnd, input bit inject, output int n);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      if (inject) begin
        f_key_valid = (i == 5) || (i == 9);
        f_key_in    = (i == 9) ? 8'h29 : 8'h1C;
      end
      step();
      if (rnd ? r_hit_valid : f_hit_valid) n = i;
    end
    f_key_valid = 1'b0;
  endtask

  task automatic count_strobes(input bit rnd, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (rnd ? r_hit_valid : f_hit_valid) cnt++;
    end
  endtask

  // One full forced-mode turn from P_WAIT back to P_WAIT
  task automatic f_turn(input logic [7:0] key, input bit inject, input int pa, input int eh,
                        input int ph, input int ea);
    int n;
    f_key_in = key;
    f_key_valid = 1'b1;
    step();
    f_key_valid = 1'b0;
    chk("p_strobe", f_hit_valid, 1);
    chk("p_enemy_hit", f_enemy_hit, eh);
    chk("p_player_hit_zero", f_player_hit, 0);
    chk("p_attack", f_p_attack, pa);
    wait_strobe(1'b0, inject, n);
    chk("e_latency", n, 18);
    if (n > 0) begin
      chk("e_player_hit", f_player_hit, ph);
      chk("e_enemy_hit_zero", f_enemy_hit, 0);
      chk("e_attack", f_e_attack, ea);
      chk("p_attack_held", f_p_attack, pa);
    end
    step();
    step();
    chk("active_after_turn", f_battle_active, 1);
  endtask

  typedef struct {
    bit         new_battle;
    bit         boss;
    logic [7:0] key;
    bit         inject;
    int         pa;
    int         eh;
    int         ph;
    int         ea;
  } fvec_t;

  fvec_t tbl[6];

  // Random-mode model state
  int         turns, n, cnt, kind, eh, ph, pa, ea, dmg, hp_e, hp_p;
  bit         rboss, guard, done, hit;
  logic [7:0] m, key, junk;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h1C, 1'b0, 1, 10, 8, 1};
    tbl[1] = '{1'b0, 1'b0, 8'h1B, 1'b1, 2, 20, 8, 1};
    tbl[2] = '{1'b0, 1'b0, 8'h23, 1'b0, 3, 0, 4, 1};
    tbl[3] = '{1'b1, 1'b1, 8'h1B, 1'b0, 2, 20, 14, 2};
    tbl[4] = '{1'b0, 1'b1, 8'h23, 1'b0, 3, 0, 7, 2};
    tbl[5] = '{1'b0, 1'b1, 8'h1C, 1'b0, 1, 10, 14, 2};

    // Reset and idle behaviour
    step();
    step();
    chk_zero("reset_outputs", 1'b0);
    f_rst = 1'b0;
    f_key_in = 8'h1C;
    f_key_valid = 1'b1;
    step();
    f_key_valid = 1'b0;
    chk("idle_key_no_strobe", f_hit_valid, 0);
    step();
    chk_zero("idle_outputs", 1'b0);

    // Vector table: each row is one full turn
    foreach (tbl[i]) begin
      if (tbl[i].new_battle) begin
        f_rst = 1'b1;
        step();
        f_rst = 1'b0;
        f_col_e = 1'b1;
        f_boss = tbl[i].boss;
        step();
        step();
        f_boss = ~tbl[i].boss;  // must be ignored: boss latched at START
        chk("battle_started", f_battle_active, 1);
      end
      f_turn(tbl[i].key, tbl[i].inject, tbl[i].pa, tbl[i].eh, tbl[i].ph, tbl[i].ea);
    end

    // Unrecognised key in P_WAIT
    f_key_in = 8'h29;
    f_key_valid = 1'b1;
    step();
    f_key_valid = 1'b0;
    chk("bad_key_no_strobe", f_hit_valid, 0);

    // Win: enemy HP reaches zero in CHECK_E
    f_key_in = 8'h1C;
    f_key_valid = 1'b1;
    step();
    f_key_valid = 1'b0;
    chk("win_p_strobe", f_enemy_hit, 10);
    f_hp_enemy = 8'd0;
    step();
    chk("win_not_over_yet", f_battle_over, 0);
    step();
    chk("win_over", f_battle_over, 1);
    chk("win_player_won", f_player_won, 1);
    chk("win_inactive", f_battle_active, 0);
    count_strobes(1'b0, 25, cnt);
    chk("win_no_enemy_strobe", cnt, 0);
    chk("win_over_held", {f_battle_over, f_player_won}, 2'b11);
    f_col_e = 1'b0;
    step();
    chk_zero("win_cleared", 1'b0);
    f_hp_enemy = 8'd80;

    // Loss, with col_e dropped mid-battle
    f_boss = 1'b0;
    f_col_e = 1'b1;
    step();
    step();
    f_key_in = 8'h1C;
    f_key_valid = 1'b1;
    step();
    f_key_valid = 1'b0;
    chk("loss_p_strobe", f_enemy_hit, 10);
    f_col_e = 1'b0;
    wait_strobe(1'b0, 1'b0, n);
    chk("loss_e_latency", n, 18);
    chk("loss_e_player_hit", f_player_hit, 8);
    f_hp_player = 8'd0;
    step();
    chk("loss_not_over_yet", f_battle_over, 0);
    step();
    chk("loss_over", f_battle_over, 1);
    chk("loss_player_won", f_player_won, 0);
    chk("loss_attacks_held", {f_p_attack, f_e_attack}, {3'd1, 3'd1});
    step();
    chk_zero("loss_cleared", 1'b0);
    f_hp_player = 8'd100;

    // Reset during E_DELAY
    f_col_e = 1'b1;
    step();
    step();
    f_key_in = 8'h1B;
    f_key_valid = 1'b1;
    step();
    f_key_valid = 1'b0;
    chk("rst_p_strobe", f_enemy_hit, 20);
    for (int i = 0; i < 6; i++) step();
    f_rst = 1'b1;
    f_col_e = 1'b0;
    step();
    chk_zero("rst_mid_battle", 1'b0);
    f_rst = 1'b0;
    count_strobes(1'b0, 30, cnt);
    chk("rst_no_strobe", cnt, 0);
    chk_zero("rst_stays_idle", 1'b0);

    // Random mode against the reference model
    step();
    r_rst = 1'b0;
    step();
    chk_zero("r_reset_outputs", 1'b1);
    turns = 0;
    while (turns < 200) begin
      rboss = 1'($urandom_range(0, 1));
      r_boss = rboss;
      hp_e = 255;
      hp_p = 255;
      r_hp_enemy = 8'd255;
      r_hp_player = 8'd255;
      guard = 1'b0;
      r_col_e = 1'b1;
      step();
      step();
      r_boss = ~rboss;
      done = 1'b0;
      while (!done && turns < 200) begin
        if ($urandom_range(0, 3) == 0) begin
          junk = 8'($urandom);
          if (junk == 8'h1C || junk == 8'h1B || junk == 8'h23) junk = 8'h29;
          r_key_in = junk;
          r_key_valid = 1'b1;
          step();
          r_key_valid = 1'b0;
          chk("r_junk_no_strobe", r_hit_valid, 0);
        end
        kind = int'($urandom_range(0, 2));
        key = (kind == 0) ? 8'h1C : (kind == 1) ? 8'h1B : 8'h23;
        r_key_in = key;
        r_key_valid = 1'b1;
        step();
        r_key_valid = 1'b0;
        turns++;
        m = m_lfsr;
        if (kind == 0) begin
          hit = (m[3:0] >= 2);
          dmg = int'(R_PBASE) + int'(m[2:0]);
          pa = hit ? 1 : 4;
          eh = hit ? ((dmg > 255) ? 255 : dmg) : 0;
        end else if (kind == 1) begin
          hit = (m[3:0] >= 8);
          dmg = 2 * int'(R_PBASE) + int'(m[3:0]);
          pa = hit ? 2 : 4;
          eh = hit ? ((dmg > 255) ? 255 : dmg) : 0;
        end else begin
          pa = 3;
          eh = 0;
          guard = 1'b1;
        end
        chk("r_p_strobe", r_hit_valid, 1);
        chk("r_p_attack", r_p_attack, pa);
        chk("r_enemy_hit", r_enemy_hit, eh);
        chk("r_p_player_hit_zero", r_player_hit, 0);
        hp_e = (hp_e > eh) ? hp_e - eh : 0;
        r_hp_enemy = 8'(hp_e);
        if (hp_e == 0) begin
          step();
          step();
          chk("r_win", {r_battle_over, r_player_won}, 2'b11);
          r_col_e = 1'b0;
          step();
          chk_zero("r_win_cleared", 1'b1);
          done = 1'b1;
        end else begin
          wait_strobe(1'b1, 1'b0, n);
          chk("r_e_latency", n, R_DELAY + 2);
          m = m_lfsr;
          dmg = int'(R_EBASE) + int'(m[2:0]) + (rboss ? int'(R_BONUS) : 0);
          if (guard) dmg = dmg / 2;
          ph = (m[7:5] == 3'd0) ? 0 : ((dmg > 127) ? 127 : dmg);
          ea = (m[7:5] == 3'd0) ? 4 : (rboss ? 2 : 1);
          guard = 1'b0;
          chk("r_player_hit", r_player_hit, ph);
          chk("r_e_attack", r_e_attack, ea);
          chk("r_e_enemy_hit_zero", r_enemy_hit, 0);
          hp_p = (hp_p > ph) ? hp_p - ph : 0;
          r_hp_player = 8'(hp_p);
          step();
          step();
          if (hp_p == 0) begin
            chk("r_loss", {r_battle_over, r_player_won}, 2'b10);
            r_col_e = 1'b0;
            step();
            chk_zero("r_loss_cleared", 1'b1);
            done = 1'b1;
          end else begin
            chk("r_active", r_battle_active, 1);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
